// File: rtl/sdcard_ram_arbiter_pkg.sv
// Shared types and bus widths for the two-master SD-card RAM arbiter.
package sdcard_ram_arbiter_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned BE_W          = 4;
  localparam int unsigned DEPTH_DEFAULT = 51200;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdcard_ram_arbiter_if.sv
// One master's request/response bundle into the RAM arbiter.
interface sdcard_ram_arbiter_if;
  import sdcard_ram_arbiter_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              err;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid, err
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid, err
  );

endinterface

// File: rtl/sdcard_ram_arb_core.sv
// Round-robin arbitration with bounded lock: owns state, lock counter and grant.
module sdcard_ram_arb_core
  import sdcard_ram_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_e       state_q, state_d;
  logic             prio_q, prio_d;   // 0: m0 wins a tie, 1: m1 wins a tie
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  // The entry grant counts as the first locked grant, so a lock yields
  // exactly LOCK_MAX consecutive grants before the other master gets a turn.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    if (reset_n) begin
      unique case (state_q)
        ARB: begin
          if (req0 && (!req1 || !prio_q)) gnt0 = 1'b1;
          else if (req1)                  gnt1 = 1'b1;
          if (gnt0 && lock0 && LOCK_MAX > 1) begin
            state_d = LOCK0;
            cnt_d   = CNT_W'(1);
          end else if (gnt1 && lock1 && LOCK_MAX > 1) begin
            state_d = LOCK1;
            cnt_d   = CNT_W'(1);
          end
        end
        LOCK0: begin
          gnt0 = req0;
          if (!req0 || !lock0 || cnt_inc >= CNT_MAX) begin
            state_d = ARB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOCK1: begin
          gnt1 = req1;
          if (!req1 || !lock1 || cnt_inc >= CNT_MAX) begin
            state_d = ARB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ARB;
          cnt_d   = '0;
        end
      endcase
      if (gnt0)      prio_d = 1'b1;
      else if (gnt1) prio_d = 1'b0;
    end
  end

endmodule

// File: rtl/sdcard_ram_arbiter.sv
// Two-master single-port RAM arbiter: request muxing, read return and range errors.
module sdcard_ram_arbiter
  import sdcard_ram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdcard_ram_arbiter_if.slave  m0,
  sdcard_ram_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [BE_W-1:0]      ram_byteenable,
  output logic [DATA_W-1:0]    ram_writedata,
  output logic                 ram_chipselect,
  output logic                 ram_write,
  output logic                 ram_clken,
  input  logic [DATA_W-1:0]    ram_readdata
);

  localparam logic [31:0]     DEPTH_W = DEPTH;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH_W[ADDR_W:0];

  logic gnt0, gnt1, gnt_any;
  logic sel_write, sel_read, in_range;
  logic rd_v0, rd_v1, rd_ok, err0, err1;

  sdcard_ram_arb_core #(
    .LOCK_MAX (LOCK_MAX)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (m0.read | m0.write),
    .req1    (m1.read | m1.write),
    .lock0   (m0.lock),
    .lock1   (m1.lock),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign gnt_any = gnt0 | gnt1;

  always_comb begin
    ram_address    = gnt1 ? m1.address    : m0.address;
    ram_byteenable = gnt1 ? m1.byteenable : m0.byteenable;
    ram_writedata  = gnt1 ? m1.writedata  : m0.writedata;
    sel_write      = gnt1 ? m1.write      : m0.write;
    sel_read       = (gnt1 ? m1.read : m0.read) & ~sel_write;
  end

  assign in_range       = {1'b0, ram_address} < DEPTH_L;
  assign ram_chipselect = gnt_any & in_range;
  assign ram_write      = gnt_any & in_range & sel_write;
  assign ram_clken      = reset_n;

  // Read ownership and range are captured at grant; the data itself comes
  // straight from the RAM output register one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v0 <= 1'b0;
      rd_v1 <= 1'b0;
      rd_ok <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      rd_v0 <= gnt0 & sel_read;
      rd_v1 <= gnt1 & sel_read;
      rd_ok <= in_range;
      err0  <= err0 | (gnt0 & ~in_range);
      err1  <= err1 | (gnt1 & ~in_range);
    end
  end

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdatavalid = rd_v0;
  assign m1.readdatavalid = rd_v1;
  assign m0.readdata      = (rd_v0 && rd_ok) ? ram_readdata : '0;
  assign m1.readdata      = (rd_v1 && rd_ok) ? ram_readdata : '0;
  assign m0.err           = err0;
  assign m1.err           = err1;

endmodule

// File: tb/tb_sdcard_ram_arbiter.sv
// Directed bench for sdcard_ram_arbiter with a cycle-level reference model.
module tb_sdcard_ram_arbiter;

  localparam int DEPTH    = 51200;
  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata;

  int checks = 0;
  int errors = 0;

  sdcard_ram_arbiter_if m0_bus ();
  sdcard_ram_arbiter_if m1_bus ();

  sdcard_ram_arbiter #(
    .DEPTH    (DEPTH),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM driven by the DUT's ram_* outputs.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin : ram_model
    logic [31:0] nw;
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        nw = mem[ram_address];
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) nw[8*b +: 8] = ram_writedata[8*b +: 8];
        mem[ram_address] <= nw;
      end
      ram_readdata <= mem[ram_address];
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected grant, RAM strobes and read returns from the rules.
  logic [31:0] gold [0:65535];
  int          last_g = 1, lock_own = -1, lock_run = 0, pend = -1;
  logic [31:0] pend_data = '0;
  logic        err_m0 = 1'b0, err_m1 = 1'b0;

  always @(negedge clk) begin : model
    logic        q0, q1, rdg, wrg, lkg, inr;
    logic [15:0] ag;
    logic [3:0]  bg;
    logic [31:0] dg;
    int          g, ai;
    if (!reset_n) begin
      chk1("rst_wait0", m0_bus.waitrequest, 1'b1);
      chk1("rst_wait1", m1_bus.waitrequest, 1'b1);
      chk1("rst_rdv0", m0_bus.readdatavalid, 1'b0);
      chk1("rst_rdv1", m1_bus.readdatavalid, 1'b0);
      chk32("rst_rdata0", m0_bus.readdata, 32'h0);
      chk32("rst_rdata1", m1_bus.readdata, 32'h0);
      chk1("rst_err0", m0_bus.err, 1'b0);
      chk1("rst_err1", m1_bus.err, 1'b0);
      chk1("rst_cs", ram_chipselect, 1'b0);
      chk1("rst_we", ram_write, 1'b0);
      chk1("rst_clken", ram_clken, 1'b0);
      last_g = 1; lock_own = -1; lock_run = 0; pend = -1; pend_data = '0;
      err_m0 = 1'b0; err_m1 = 1'b0;
    end else begin
      q0 = m0_bus.read | m0_bus.write;
      q1 = m1_bus.read | m1_bus.write;
      g = -1;
      if (lock_own == 0)      begin if (q0) g = 0; end
      else if (lock_own == 1) begin if (q1) g = 1; end
      else if (q0 && q1)      g = (last_g == 0) ? 1 : 0;
      else if (q0)            g = 0;
      else if (q1)            g = 1;

      chk1("wait0", m0_bus.waitrequest, g != 0);
      chk1("wait1", m1_bus.waitrequest, g != 1);
      chk1("rdv0", m0_bus.readdatavalid, pend == 0);
      chk1("rdv1", m1_bus.readdatavalid, pend == 1);
      chk32("rdata0", m0_bus.readdata, (pend == 0) ? pend_data : 32'h0);
      chk32("rdata1", m1_bus.readdata, (pend == 1) ? pend_data : 32'h0);
      chk1("err0", m0_bus.err, err_m0);
      chk1("err1", m1_bus.err, err_m1);
      chk1("clken", ram_clken, 1'b1);

      if (g >= 0) begin
        rdg = (g == 0) ? m0_bus.read       : m1_bus.read;
        wrg = (g == 0) ? m0_bus.write      : m1_bus.write;
        lkg = (g == 0) ? m0_bus.lock       : m1_bus.lock;
        ag  = (g == 0) ? m0_bus.address    : m1_bus.address;
        bg  = (g == 0) ? m0_bus.byteenable : m1_bus.byteenable;
        dg  = (g == 0) ? m0_bus.writedata  : m1_bus.writedata;
        ai  = int'(ag);
        inr = ai < DEPTH;
        chk32("ram_addr", 32'(ram_address), 32'(ag));
        chk32("ram_be", 32'(ram_byteenable), 32'(bg));
        chk32("ram_wdata", ram_writedata, dg);
        chk1("ram_cs", ram_chipselect, inr);
        chk1("ram_we", ram_write, inr & wrg);
        pend      = (rdg && !wrg) ? g : -1;
        pend_data = inr ? gold[ai] : 32'h0;
        if (wrg && inr)
          for (int b = 0; b < 4; b++)
            if (bg[b]) gold[ai][8*b +: 8] = dg[8*b +: 8];
        if (!inr) begin
          if (g == 0) err_m0 = 1'b1; else err_m1 = 1'b1;
        end
        last_g = g;
      end else begin
        lkg = 1'b0;
        chk1("idle_cs", ram_chipselect, 1'b0);
        chk1("idle_we", ram_write, 1'b0);
        pend = -1;
      end

      if (lock_own >= 0) begin
        if (g == lock_own && lkg) begin
          lock_run++;
          if (lock_run >= LOCK_MAX) lock_own = -1;
        end else begin
          lock_own = -1;
        end
      end else if (g >= 0 && lkg) begin
        lock_own = g;
        lock_run = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic lk);
    if (m == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.writedata = d; m0_bus.byteenable = be; m0_bus.lock = lk;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.writedata = d; m1_bus.byteenable = be; m1_bus.lock = lk;
    end
  endtask

  task automatic idle(input int m);
    drive(m, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_xfer(input int m, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    bit ok;
    ok = 1'b0;
    drive(m, rd, wr, a, d, be, 1'b0);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (((m == 0) ? m0_bus.waitrequest : m1_bus.waitrequest) == 1'b0) ok = 1'b1;
      else step();
    end
    if (!ok) chk1("accept_timeout", 1'b0, 1'b1);
    step();
    idle(m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : directed
    logic [7:0] pat0, pat1;
    int  i0, i1, run, cyc;
    bit  gw0, gw1, got;
    idle(0);
    idle(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_clken_lit", ram_clken, 1'b0);
    step();
    reset_n = 1'b1;

    // Both masters write 4 words each; grants must alternate m0,m1,...
    pat0 = 8'b0101_0101;
    pat1 = 8'b1010_1010;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (i0 < 4) drive(0, 1'b0, 1'b1, 16'(i0), 32'hA000_0000 + i0, 4'hF, 1'b0);
      else        idle(0);
      if (i1 < 4) drive(1, 1'b0, 1'b1, 16'(100 + i1), 32'hB000_0000 + i1, 4'hF, 1'b0);
      else        idle(1);
      @(negedge clk);
      gw0 = !m0_bus.waitrequest;
      gw1 = !m1_bus.waitrequest;
      chk1("rr_m0_grant", gw0, pat0[k]);
      chk1("rr_m1_grant", gw1, pat1[k]);
      step();
      if (gw0) i0++;
      if (gw1) i1++;
    end
    idle(0);
    idle(1);
    for (int j = 0; j < 4; j++) begin
      chk32("ram_m0_word", mem[j], 32'hA000_0000 + j);
      chk32("ram_m1_word", mem[100 + j], 32'hB000_0000 + j);
    end

    // Byte-lane merge
    do_xfer(0, 1'b0, 1'b1, 16'd7, 32'hFFFF_FFFF, 4'hF);
    do_xfer(0, 1'b0, 1'b1, 16'd7, 32'h1122_3344, 4'b0101);
    do_xfer(0, 1'b1, 1'b0, 16'd7, 32'h0, 4'hF);
    @(negedge clk);
    chk1("be_rdv", m0_bus.readdatavalid, 1'b1);
    chk32("be_merge", m0_bus.readdata, 32'hFF22_FF44);
    step();

    // Pipelined reads from both masters, no cross-delivery
    do_xfer(0, 1'b0, 1'b1, 16'd5, 32'hDEAD_BEEF, 4'hF);
    do_xfer(1, 1'b0, 1'b1, 16'd6, 32'h1234_5678, 4'hF);
    drive(0, 1'b1, 1'b0, 16'd5, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("pipe_g0", m0_bus.waitrequest, 1'b0);
    step();
    idle(0);
    drive(1, 1'b1, 1'b0, 16'd6, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("pipe_rdv0", m0_bus.readdatavalid, 1'b1);
    chk32("pipe_rd0", m0_bus.readdata, 32'hDEAD_BEEF);
    chk1("pipe_rdv1_early", m1_bus.readdatavalid, 1'b0);
    chk1("pipe_g1", m1_bus.waitrequest, 1'b0);
    step();
    idle(1);
    @(negedge clk);
    chk1("pipe_rdv1", m1_bus.readdatavalid, 1'b1);
    chk32("pipe_rd1", m1_bus.readdata, 32'h1234_5678);
    chk1("pipe_rdv0_late", m0_bus.readdatavalid, 1'b0);
    chk32("pipe_rd0_zero", m0_bus.readdata, 32'h0);
    step();

    // Lock limit: m0 keeps LOCK_MAX grants, then m1 gets the next cycle
    drive(0, 1'b1, 1'b0, 16'd0, 32'h0, 4'hF, 1'b1);
    drive(1, 1'b1, 1'b0, 16'd100, 32'h0, 4'hF, 1'b0);
    run = 0; cyc = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (!m1_bus.waitrequest) got = 1'b1;
      else begin
        cyc++;
        if (!m0_bus.waitrequest) run++;
      end
      step();
    end
    idle(0);
    idle(1);
    chk1("lock_m1_granted", got, 1'b1);
    chk32("lock_run", 32'(run), 32'd16);
    chk32("lock_cycles", 32'(cyc), 32'd16);

    // Locked owner going idle stalls the other master for that cycle
    drive(0, 1'b0, 1'b1, 16'd10, 32'h0000_0010, 4'hF, 1'b1);
    drive(1, 1'b0, 1'b1, 16'd11, 32'h0000_0011, 4'hF, 1'b0);
    @(negedge clk);
    chk1("lkidle_g0", m0_bus.waitrequest, 1'b0);
    step();
    idle(0);
    @(negedge clk);
    chk1("lkidle_stall1", m1_bus.waitrequest, 1'b1);
    step();
    @(negedge clk);
    chk1("lkidle_g1", m1_bus.waitrequest, 1'b0);
    step();
    idle(1);

    // Out-of-range accesses from m1, last in-range word from m0
    drive(1, 1'b0, 1'b1, 16'd51200, 32'hBAD0_BAD0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("oor_wr_accept", m1_bus.waitrequest, 1'b0);
    chk1("oor_wr_no_we", ram_write, 1'b0);
    chk1("oor_wr_no_cs", ram_chipselect, 1'b0);
    step();
    drive(1, 1'b1, 1'b0, 16'hFFFF, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("oor_rd_accept", m1_bus.waitrequest, 1'b0);
    step();
    idle(1);
    @(negedge clk);
    chk1("oor_rd_rdv", m1_bus.readdatavalid, 1'b1);
    chk32("oor_rd_zero", m1_bus.readdata, 32'h0);
    chk1("oor_err1", m1_bus.err, 1'b1);
    chk1("oor_err0", m0_bus.err, 1'b0);
    step();
    do_xfer(0, 1'b0, 1'b1, 16'd51199, 32'h5A5A_5A5A, 4'hF);
    do_xfer(0, 1'b1, 1'b0, 16'd51199, 32'h0, 4'hF);
    @(negedge clk);
    chk32("edge_rd", m0_bus.readdata, 32'h5A5A_5A5A);
    chk1("edge_err0", m0_bus.err, 1'b0);
    step();

    // Reset right after an m0 read grant
    drive(0, 1'b1, 1'b0, 16'd5, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("rr_pre_g0", m0_bus.waitrequest, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(1, 1'b1, 1'b0, 16'd6, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("rr_no_rdv0", m0_bus.readdatavalid, 1'b0);
    chk32("rr_rd0_zero", m0_bus.readdata, 32'h0);
    chk1("rr_err1_clr", m1_bus.err, 1'b0);
    chk1("rr_cs", ram_chipselect, 1'b0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk1("rr_post_g0", m0_bus.waitrequest, 1'b0);
    chk1("rr_post_w1", m1_bus.waitrequest, 1'b1);
    chk1("rr_post_rdv0", m0_bus.readdatavalid, 1'b0);
    step();
    idle(0);
    idle(1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
